// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage iterative divider: state codes,
// handshake levels, the 64-bit HI/LO bus type and the two's-complement helper.
package div_unit_pkg;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   localparam logic [5:0] DivSteps = 6'd32;

   typedef logic [63:0] DoubleRegBus;

   // Wraps at 32 bits, so neg32(32'h8000_0000) == 32'h8000_0000.
   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per clock,
// {remainder, quotient} held on result_o while ready_o is high.
module div_unit
   import div_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   div_state_e  r_state;
   logic [5:0]  r_cnt;
   logic [64:0] r_work;
   logic [31:0] r_divisor;
   logic        r_neg_quot;
   logic        r_neg_rem;
   DoubleRegBus r_result;
   logic        r_ready;

   logic        w_accept;
   logic [31:0] w_abs_dividend;
   logic [31:0] w_abs_divisor;
   logic [32:0] w_trial;
   logic [31:0] w_quot;
   logic [31:0] w_rem;

   assign w_accept       = (start_i == DivStart) && !annul_i;
   assign w_abs_dividend = (signed_div_i && opdata1_i[31]) ? neg32(opdata1_i) : opdata1_i;
   assign w_abs_divisor  = (signed_div_i && opdata2_i[31]) ? neg32(opdata2_i) : opdata2_i;

   // Magnitudes are treated as unsigned, so the trial subtract is a plain 33-bit borrow test.
   assign w_trial = {1'b0, r_work[63:32]} - {1'b0, r_divisor};
   assign w_quot  = r_neg_quot ? neg32(r_work[31:0])  : r_work[31:0];
   assign w_rem   = r_neg_rem  ? neg32(r_work[64:33]) : r_work[64:33];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= DivFree;
         r_cnt    <= '0;
         r_ready  <= DivResultNotReady;
         r_result <= '0;
      end else begin
         case (r_state)
            DivFree: begin
               r_ready  <= DivResultNotReady;
               r_result <= '0;
               if (w_accept) begin
                  if (opdata2_i == 32'd0) begin
                     r_state <= DivByZero;
                  end else begin
                     r_state    <= DivOn;
                     r_cnt      <= '0;
                     r_work     <= {32'b0, w_abs_dividend, 1'b0};
                     r_divisor  <= w_abs_divisor;
                     r_neg_quot <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                     r_neg_rem  <= signed_div_i & opdata1_i[31];
                  end
               end
            end
            DivByZero: begin
               r_state  <= DivEnd;
               r_result <= '0;
               r_ready  <= DivResultReady;
            end
            DivOn: begin
               if (annul_i) begin
                  r_state  <= DivFree;
                  r_ready  <= DivResultNotReady;
                  r_result <= '0;
               end else if (r_cnt != DivSteps) begin
                  if (w_trial[32])
                     r_work <= {r_work[63:0], 1'b0};
                  else
                     r_work <= {w_trial[31:0], r_work[31:0], 1'b1};
                  r_cnt <= r_cnt + 6'd1;
               end else begin
                  r_state  <= DivEnd;
                  r_result <= {w_rem, w_quot};
                  r_ready  <= DivResultReady;
               end
            end
            DivEnd: begin
               // Result is held for as long as EX keeps the request up.
               if (!w_accept) begin
                  r_state  <= DivFree;
                  r_ready  <= DivResultNotReady;
                  r_result <= '0;
               end
            end
            default: r_state <= DivFree;
         endcase
      end
   end

   assign result_o = r_result;
   assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed quotient/remainder pairs,
// divide-by-zero, annul, END hold and mid-operation reset.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int n_checks = 0;
   int n_pass   = 0;

   div_unit dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept at E0, scramble the operand inputs, run E1..E33 and check the result.
   task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input bit gap);
      logic seen;
      signed_div_i = sg;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      annul_i      = 1'b0;
      tick();
      opdata1_i    = ~a;
      opdata2_i    = b ^ 32'h5A5A_0003;
      signed_div_i = ~sg;
      seen = ready_o;
      for (int i = 1; i <= 32; i++) begin
         if (gap) start_i = (i >= 5 && i < 12) ? 1'b0 : 1'b1;
         tick();
         if (ready_o) seen = 1'b1;
      end
      start_i = 1'b1;
      tick();
      check({tag, " early_ready"}, {63'b0, seen}, 64'd0);
      check({tag, " ready"}, {63'b0, ready_o}, 64'd1);
      check({tag, " result"}, result_o, exp);
   endtask

   task automatic stop_op(input string tag);
      start_i = 1'b0;
      tick();
      check({tag, " stop_ready"}, {63'b0, ready_o}, 64'd0);
      check({tag, " stop_result"}, result_o, 64'd0);
   endtask

   task automatic expect_idle(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (ready_o) seen = 1'b1;
      end
      check({tag, " no_ready"}, {63'b0, seen}, 64'd0);
   endtask

   initial begin
      rst          = 1'b1;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      tick();
      tick();
      check("reset ready", {63'b0, ready_o}, 64'd0);
      check("reset result", result_o, 64'd0);
      rst = 1'b0;
      tick();

      // 100 / 7 = 14 r 2, then hold END three cycles
      run_div("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold ready", {63'b0, ready_o}, 64'd1);
         check("hold result", result_o, {32'd2, 32'd14});
      end
      stop_op("u100_7");

      // New start right after returning to FREE; start dropped mid-run must not cancel
      run_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
      stop_op("s-7_2");

      run_div("smin_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0);
      stop_op("smin_m1");

      // Divide by zero
      signed_div_i = 1'b0;
      opdata1_i    = 32'd1234;
      opdata2_i    = 32'd0;
      start_i      = 1'b1;
      tick();
      check("dbz E0 ready", {63'b0, ready_o}, 64'd0);
      tick();
      check("dbz E1 ready", {63'b0, ready_o}, 64'd1);
      check("dbz E1 result", result_o, 64'd0);
      stop_op("dbz");

      // Annul at E10
      signed_div_i = 1'b0;
      opdata1_i    = 32'hFFFF_FFFF;
      opdata2_i    = 32'h10;
      start_i      = 1'b1;
      tick();
      for (int i = 1; i <= 9; i++) tick();
      annul_i = 1'b1;
      start_i = 1'b0;
      tick();
      annul_i = 1'b0;
      expect_idle("annul", 40);
      run_div("u_ffff_10", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'h0000_000F, 32'h0FFF_FFFF}, 1'b0);
      stop_op("u_ffff_10");

      // annul together with start in FREE blocks the accept
      opdata1_i = 32'd50;
      opdata2_i = 32'd5;
      start_i   = 1'b1;
      annul_i   = 1'b1;
      tick();
      start_i   = 1'b0;
      annul_i   = 1'b0;
      expect_idle("blocked", 40);

      // Reset at E20 of a divide
      opdata1_i = 32'd1000;
      opdata2_i = 32'd3;
      start_i   = 1'b1;
      tick();
      for (int i = 1; i <= 19; i++) tick();
      rst = 1'b1;
      tick();
      rst     = 1'b0;
      start_i = 1'b0;
      check("rst ready", {63'b0, ready_o}, 64'd0);
      check("rst result", result_o, 64'd0);
      expect_idle("post_rst", 40);
      run_div("u9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0);
      stop_op("u9_3");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit divider for the EX stage; consumes operands and divide ops issued through the ID/EX pipeline register.
- Handles DIV (signed) and DIVU (unsigned) using a radix-2 restoring algorithm, one quotient bit per cycle.
- EX holds a pipeline stall request while the divider is busy and writes {remainder, quotient} to HI/LO when ready_o rises.

Parameters:
- none (datapath fixed at 32 bits, 32 iterations)

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept.
- opdata1_i  in  32  dividend; sampled at accept.
- opdata2_i  in  32  divisor; sampled at accept.
- start_i  in  1  request or hold a divide; level-sensitive.
- annul_i  in  1  cancel the operation in flight (EX flush, branch-delay squash).
- result_o  out  64  {remainder[63:32], quotient[31:0]}; valid only while ready_o = 1.
- ready_o  out  1  result valid.

Behaviour:
- Reset: state FREE, ready_o = 0, result_o = 0, counter = 0. Applies from any state, including mid-ON.
- States are FREE, BYZERO, ON and END. All outputs are registered.
- FREE:
  - Accept occurs when start_i = 1 and annul_i = 0.
  - If the divisor is 0, go to BYZERO.
  - Otherwise latch operands and go to ON with cnt = 0.
  - In signed mode, latch the absolute values and record the dividend and divisor signs.
  - Working register: 65 bits, initialised to {32'b0, |dividend|, 1'b0}.
  - With no accept, stay in FREE; ready_o = 0, result_o = 0.
- BYZERO: on the next edge go to END with result_o = 0 and ready_o = 1.
- ON, each edge:
  - If annul_i = 1, go to FREE; ready_o = 0, result_o = 0.
  - Otherwise perform one step: trial = {1'b0, work[63:32]} − {1'b0, |divisor|}.
  - If trial[32] = 1 (borrow), shift work left by 1.
  - Else set work = {trial[31:0], work[31:0], 1'b1}.
  - Increment cnt.
  - Dropping start_i does not cancel; only annul_i does.
- After 32 steps (cnt = 32), the next edge goes to END:
  - quotient = work[31:0]; remainder = work[64:33].
  - Signed correction: negate the quotient if the operand signs differ; the remainder takes the dividend's sign (negate if the dividend is negative).
  - Load result_o and set ready_o = 1.
- Latency: accept edge = E0. Steps occur on E1..E32. ready_o = 1 after E33. For divide-by-zero, ready_o = 1 after E1.
- END:
  - While start_i = 1, hold state, result_o and ready_o.
  - When start_i = 0, the next edge goes to FREE with ready_o = 0 and result_o = 0.
  - annul_i in END behaves as start_i = 0.
- Boundary cases:
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0; no trap.
  - Operand changes after accept are ignored.
  - annul_i = 1 together with start_i = 1 in FREE blocks the accept.
- Arithmetic: unsigned 33-bit trial subtraction. Abs and negate are two's complement over 32 bits, and abs(0x80000000) = 0x80000000 treated as unsigned.

Decomposition:
- Add to defines.v:
  - State codes: DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
  - Handshake constants: DivResultReady/DivResultNotReady, DivStart/DivStop.
  - DoubleRegBus [63:0].
- No sub-module. The per-step subtract/shift is a few lines and stays inline in the single sequential block.

Test Plan:
- Unsigned 100 / 7, start held high → after E33: ready_o = 1, result_o = {0x00000002, 0x0000000E}; ready_o is 0 on every earlier cycle.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also signed 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}.
- Divisor 0, start = 1 → after E1: ready_o = 1, result_o = 0; drop start → next edge ready_o = 0, state FREE.
- Unsigned 0xFFFFFFFF / 0x10, annul_i pulsed at E10 → ready_o never rises. Restart with the same operands → result {0x0000000F, 0x0FFFFFFF} at E33 of the new op.
- Hold start in END for 3 cycles → result and ready stable. Then start = 0 → ready_o = 0 and result_o = 0 after one edge. A new start in the following cycle is accepted.
- Assert rst at E20 of a divide → after that edge, ready_o = 0, result_o = 0, state FREE. A subsequent 9 / 3 unsigned gives {0, 3} at E33.
